// File: rtl/inv_sbox_iter.sv
// inv_sbox_iter: four-lane AES inverse S-box built around an iterative
// GF(2^8) exponentiation (x^254 by square-and-multiply, one step per clock).
// Each lane applies the inverse affine map, then raises the result to the
// 254th power, which is the multiplicative inverse (0 maps to 0).
// Optional feature: define INV_SBOX_ITER_FWD_EN to add the `fwd` input.
// With fwd = 1 the block computes the forward S-box instead.
// The latency and the handshake are the same in both modes.
module inv_sbox_iter (
   input  logic        clk,
   input  logic        rst_n,
`ifdef INV_SBOX_ITER_FWD_EN
   input  logic        fwd,
`endif
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, EXP, DONE} state_t;

   // Final exponent step: squaring only, no multiply by x.
   localparam logic [2:0] LAST_CNT = 3'd6;

   state_t      state_q, state_d;
   logic [31:0] x_q, x_d;
   logic [31:0] r_q, r_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] out_q, out_d;
   logic        fwd_q, fwd_d;

   // Per-lane datapath results.
   logic [31:0] sq_w, sqx_w, pre_w, post_w;
   logic        fwd_in_w;

   // GF(2^8) multiply, shift-and-reduce modulo x^8+x^4+x^3+x+1 (0x11B).
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1B) : {aa[6:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int unsigned n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [7:0] inv_affine(input logic [7:0] s);
      return rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05;
   endfunction

   function automatic logic [7:0] fwd_affine(input logic [7:0] b);
      return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
   endfunction

`ifdef INV_SBOX_ITER_FWD_EN
   assign fwd_in_w = fwd;
`else
   assign fwd_in_w = 1'b0;
`endif

   // Four identical, independent lanes: pre-affine, square, square-times-x, post-map.
   always_comb begin
      sq_w   = '0;
      sqx_w  = '0;
      pre_w  = '0;
      post_w = '0;
      for (int l = 0; l < 4; l++) begin
         sq_w[8*l +: 8]   = gf_mul(r_q[8*l +: 8], r_q[8*l +: 8]);
         sqx_w[8*l +: 8]  = gf_mul(sq_w[8*l +: 8], x_q[8*l +: 8]);
         pre_w[8*l +: 8]  = fwd_in_w ? in[8*l +: 8] : inv_affine(in[8*l +: 8]);
         post_w[8*l +: 8] = fwd_q ? fwd_affine(sq_w[8*l +: 8]) : sq_w[8*l +: 8];
      end
   end

   // Next-state logic: accept in IDLE, one exponent step per cycle in EXP, hold in DONE.
   always_comb begin
      // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
      state_d = state_q;
      x_d     = x_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      fwd_d   = fwd_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               x_d     = pre_w;
               r_d     = pre_w;
               cnt_d   = 3'd0;
               fwd_d   = fwd_in_w;
               state_d = EXP;
            end
         end
         EXP: begin
            r_d   = (cnt_q < LAST_CNT) ? sqx_w : sq_w;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == LAST_CNT) begin
               out_d   = post_w;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset is synchronous and overrides any transaction in flight.
   always_ff @(posedge clk) begin
      // NOTE: registers take non-blocking assignments so every flop samples pre-edge values, whatever the statement order.
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         fwd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         fwd_q   <= fwd_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out       = out_q;

endmodule

// File: tb/tb_inv_sbox_iter.sv
// Self-checking bench for inv_sbox_iter. Expected S-box values come from
// tables built here. Each field inverse is found by brute-force search, and
// each affine map is applied directly from its defining rotation formula.
module tb_inv_sbox_iter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out;
   logic        busy;
   logic        fwd_drv;

   int checks = 0;
   int errors = 0;

   logic [7:0] inv_t [256];
   logic [7:0] isb   [256];
   logic [7:0] fsb   [256];

   always #5 clk = ~clk;

   inv_sbox_iter dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef INV_SBOX_ITER_FWD_EN
      .fwd       (fwd_drv),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .busy      (busy)
   );

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      int acc = 0;
      int aa  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ aa;
         aa = aa * 2;
         if (aa >= 256) aa = aa ^ 'h11B;
      end
      return acc[7:0];
   endfunction

   function automatic logic [7:0] rot(input logic [7:0] v, input int n);
      int w = v;
      w = (w * (1 << n)) | (w >> (8 - n));
      return w[7:0];
   endfunction

   task automatic build_tables();
      inv_t[0] = 8'h00;
      for (int a = 1; a < 256; a++)
         for (int b = 1; b < 256; b++)
            if (gmul(a[7:0], b[7:0]) == 8'h01) begin
               inv_t[a] = b[7:0];
               break;
            end
      for (int s = 0; s < 256; s++) begin
         logic [7:0] sb, b, t;
         sb = s[7:0];
         b  = rot(sb, 1) ^ rot(sb, 3) ^ rot(sb, 6) ^ 8'h05;
         isb[s] = inv_t[b];
         t  = inv_t[s];
         fsb[s] = t ^ rot(t, 1) ^ rot(t, 2) ^ rot(t, 3) ^ rot(t, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] ref_word(input logic [31:0] w, input logic f);
      logic [31:0] r;
      for (int l = 0; l < 4; l++)
         r[8*l +: 8] = f ? fsb[w[8*l +: 8]] : isb[w[8*l +: 8]];
      return r;
   endfunction

   // ---------------- stimulus driver ----------------
   // Runs one transaction and reports what was observed; callers compare.
   task automatic do_txn(input logic [31:0] word, input logic f, input int hold,
                         output logic [31:0] got, output int lat, output bit held_ok,
                         output bit valid_after, output bit idle_after,
                         output logic [31:0] out_after);
      int guard = 0;
      while (!in_ready && guard < 20) begin
         @(posedge clk); #1; guard++;
      end
      in       = word;
      fwd_drv  = f;
      in_valid = 1'b1;
      out_ready = (hold == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in       = $urandom;
      fwd_drv  = $urandom_range(0, 1);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      if (!out_valid) lat = -1;
      got = out;
      held_ok = 1'b1;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         if (out !== got || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
            held_ok = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      valid_after = out_valid;
      idle_after  = in_ready;
      out_after   = out;
      out_ready   = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; in = 32'h1234_5678; out_ready = 1'b0; fwd_drv = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out !== 32'h0) begin
         errors++;
         $display("FAIL reset_state: in_ready=%b busy=%b out_valid=%b out=%h, required 1 0 0 00000000",
                  in_ready, busy, out_valid, out);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_priority: busy=%b after reset with in_valid high, required 0", busy);
      end
   endtask

   task automatic test_vectors();
      logic [31:0] words [3] = '{32'h637C7716, 32'h00000000, 32'h16161616};
      logic [31:0] exps  [3] = '{32'h000102FF, 32'h52525252, 32'hFFFFFFFF};
      logic [31:0] got, oa;
      int lat; bit ho, va, ia;
      for (int i = 0; i < 3; i++) begin
         do_txn(words[i], 1'b0, 0, got, lat, ho, va, ia, oa);
         checks++;
         if (got !== exps[i]) begin
            errors++;
            $display("FAIL vector_%0d: out=%h, required %h", i, got, exps[i]);
         end
         checks++;
         if (lat !== 7) begin
            errors++;
            $display("FAIL latency_%0d: latency=%0d, required 7", i, lat);
         end
         checks++;
         if (va !== 1'b0 || ia !== 1'b1 || oa !== exps[i]) begin
            errors++;
            $display("FAIL one_cycle_valid_%0d: out_valid=%b in_ready=%b out=%h, required 0 1 %h",
                     i, va, ia, oa, exps[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] got, oa, w, e;
      int lat; bit ho, va, ia;
      w = $urandom;
      e = ref_word(w, 1'b0);
      do_txn(w, 1'b0, 5, got, lat, ho, va, ia, oa);
      checks++;
      if (got !== e || lat !== 7) begin
         errors++;
         $display("FAIL bp_result: out=%h lat=%0d, required %h 7", got, lat, e);
      end
      checks++;
      if (ho !== 1'b1) begin
         errors++;
         $display("FAIL bp_hold: stable=%b, required 1", ho);
      end
      checks++;
      if (va !== 1'b0 || ia !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", va, ia);
      end
   endtask

   task automatic test_reset_mid_exp();
      logic [31:0] got, oa, w;
      int lat; bit ho, va, ia;
      in = 32'hA5A5_3C3C; fwd_drv = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 32'h0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_exp: in_ready=%b out_valid=%b out=%h busy=%b, required 1 0 00000000 0",
                  in_ready, out_valid, out, busy);
      end
      repeat (12) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_emit: out_valid=%b, required 0", out_valid);
         end
      end
      w = 32'h52_09_6A_D5;
      do_txn(w, 1'b0, 1, got, lat, ho, va, ia, oa);
      checks++;
      if (got !== ref_word(w, 1'b0) || lat !== 7) begin
         errors++;
         $display("FAIL after_reset_txn: out=%h lat=%0d, required %h 7", got, lat, ref_word(w, 1'b0));
      end
   endtask

   task automatic test_exhaustive(input logic f);
      logic [31:0] got, oa, w, e;
      int lat; bit ho, va, ia;
      int bad = 0;
      for (int i = 0; i < 256; i++) begin
         w = {8'(i + 192), 8'(i + 128), 8'(i + 64), 8'(i)};
         e = ref_word(w, f);
         do_txn(w, f, 0, got, lat, ho, va, ia, oa);
         checks++;
         if (got !== e || lat !== 7) begin
            errors++;
            bad++;
            if (bad < 10)
               $display("FAIL exhaustive fwd=%b in=%h: out=%h lat=%0d, required %h 7", f, w, got, lat, e);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] got, oa, w, e;
      logic f;
      int lat, hold; bit ho, va, ia;
      for (int i = 0; i < 40; i++) begin
         w = $urandom;
`ifdef INV_SBOX_ITER_FWD_EN
         f = $urandom_range(0, 1);
`else
         f = 1'b0;
`endif
         hold = $urandom_range(0, 3);
         e = ref_word(w, f);
         do_txn(w, f, hold, got, lat, ho, va, ia, oa);
         checks++;
         if (got !== e || lat !== 7 || ho !== 1'b1 || va !== 1'b0 || oa !== e) begin
            errors++;
            $display("FAIL random_%0d in=%h fwd=%b: out=%h lat=%0d hold_ok=%b valid_after=%b, required %h 7 1 0",
                     i, w, f, got, lat, ho, va, e);
         end
      end
   endtask

`ifdef INV_SBOX_ITER_FWD_EN
   task automatic test_fwd();
      logic [31:0] got, oa;
      int lat; bit ho, va, ia;
      do_txn(32'h00010253, 1'b1, 0, got, lat, ho, va, ia, oa);
      checks++;
      if (got !== 32'h637C77ED || lat !== 7) begin
         errors++;
         $display("FAIL fwd_vector: out=%h lat=%0d, required 637c77ed 7", got, lat);
      end
      do_txn(32'h637C77ED, 1'b0, 0, got, lat, ho, va, ia, oa);
      checks++;
      if (got !== 32'h00010253 || lat !== 7) begin
         errors++;
         $display("FAIL inv_roundtrip: out=%h lat=%0d, required 00010253 7", got, lat);
      end
      test_exhaustive(1'b1);
   endtask
`endif

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in = '0; out_ready = 1'b0; fwd_drv = 1'b0;
      build_tables();
      test_reset();
      test_vectors();
      test_backpressure();
      test_reset_mid_exp();
      test_exhaustive(1'b0);
      test_random();
`ifdef INV_SBOX_ITER_FWD_EN
      test_fwd();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
